// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract: one N-bit carry-lookahead slice reused over K cycles, LS slice first.
// Latency: K cycles from request acceptance to res_valid; minimum issue interval K+2 cycles.
// Backpressure: result held in DONE while res_ready is low; start_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   start_valid/start_ready request handshake; a, b, sub are sampled on acceptance
//   res_valid/res_ready     result handshake; result, carry, overflow are valid with res_valid
//   busy                    high while an operation is in progress or awaiting pickup
module cla_mp_sequencer #(
   parameter int N = 4,
   parameter int K = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic             sub,
   input  logic [N*K-1:0]   a,
   input  logic [N*K-1:0]   b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [N*K-1:0]   result,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam int W  = N * K;
   localparam int IW = (K > 1) ? $clog2(K) : 1;
   localparam logic [IW-1:0] LAST = IW'(K - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic            sub_reg;
   logic            carry_reg;

   // Current slice operands; subtraction inverts b and relies on carry_reg
   // having been seeded with 1 at acceptance.
   logic [N-1:0]    x;
   logic [N-1:0]    y;
   logic [N-1:0]    g;
   logic [N-1:0]    p;
   logic [N:0]      c;
   logic [N-1:0]    s;
   logic            cout;
   logic            ci;
   logic            pp;

   always_comb begin
      x = a_reg[int'(idx)*N +: N];
      y = b_reg[int'(idx)*N +: N] ^ {N{sub_reg}};
   end

   // Carry-lookahead: every carry is formed directly from generate/propagate
   // terms and the slice carry-in, not from the previous bit's carry.
   always_comb begin
      g  = x & y;
      p  = x ^ y;
      c  = '0;
      ci = 1'b0;
      pp = 1'b0;
      c[0] = carry_reg;
      for (int i = 0; i < N; i++) begin
         ci = g[i];
         pp = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            ci = ci | (pp & g[j]);
            pp = pp & p[j];
         end
         ci = ci | (pp & carry_reg);
         c[i+1] = ci;
      end
      s    = p ^ c[N-1:0];
      cout = c[N];
   end

   assign start_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  sub_reg   <= sub;
                  carry_reg <= sub;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               result[int'(idx)*N +: N] <= s;
               carry_reg                <= cout;
               idx                      <= idx + 1'b1;
               if (idx == LAST) begin
                  carry     <= cout;
                  // Signed overflow: operands agree in sign, sum sign differs.
                  overflow  <= (x[N-1] ~^ y[N-1]) & (s[N-1] ^ x[N-1]);
                  res_valid <= 1'b1;
                  idx       <= '0;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
module tb_cla_mp_sequencer;

   localparam int N = 4;
   localparam int K = 4;
   localparam int W = N * K;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start_valid = 1'b0;
   logic           start_ready;
   logic           sub = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           res_valid;
   logic           res_ready = 1'b1;
   logic [W-1:0]   result;
   logic           carry;
   logic           overflow;
   logic           busy;

   int nvec = 0;
   int nerr = 0;

   cla_mp_sequencer #(.N(N), .K(K)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .sub         (sub),
      .a           (a),
      .b           (b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .carry       (carry),
      .overflow    (overflow),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic. Returns {overflow, carry, result}.
   function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int           sx, sy, r;
      logic         o, c;
      logic [W-1:0] res;
      sx  = int'($signed(x));
      sy  = int'($signed(y));
      r   = s ? (sx - sy) : (sx + sy);
      o   = (r > 32767) || (r < -32768);
      c   = s ? (x >= y) : ((int'(x) + int'(y)) > 65535);
      res = s ? (x - y) : (x + y);
      return {o, c, res};
   endfunction

   // Model: in flight or not, and edges elapsed since acceptance.
   bit           m_busy = 1'b0;
   int           m_age = 0;
   logic [W-1:0] m_res = '0;
   logic         m_c = 1'b0;
   logic         m_o = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_result", result, 0);
         chk("rst_carry", carry, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_start_ready", start_ready, 1);
         m_busy = 1'b0;
      end else begin
         chk("res_valid", res_valid, (m_busy && m_age >= K));
         chk("busy", busy, m_busy);
         chk("start_ready", start_ready, !m_busy);
         if (m_busy && m_age >= K) begin
            chk("result", result, m_res);
            chk("carry", carry, m_c);
            chk("overflow", overflow, m_o);
         end
         // Advance the model across the coming rising edge.
         if (!m_busy) begin
            if (start_valid) begin
               {m_o, m_c, m_res} = ref_op(a, b, sub);
               m_busy = 1'b1;
               m_age  = 0;
            end
         end else if (m_age >= K && res_ready) begin
            m_busy = 1'b0;
         end else begin
            m_age++;
         end
      end
   end

   // Called and returns at 1 time unit after a rising edge.
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                     input bit lit, input logic [W-1:0] er, input logic ec, input logic eo,
                     input int hold);
      bit           acc;
      bit           got;
      logic [W-1:0] held;
      a           = ta;
      b           = tb_;
      sub         = ts;
      start_valid = 1'b1;
      res_ready   = (hold == 0);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = start_ready;
         @(posedge clk);
      end
      #1;
      start_valid = 1'b0;
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      if (!acc) begin
         nvec++; nerr++;
         $display("FAIL accept_timeout: request not accepted at %0t", $time);
      end
      got = 1'b0;
      for (int t = 0; t < K + 4 && !got; t++) begin
         @(negedge clk);
         got = res_valid;
      end
      if (!got) begin
         nvec++; nerr++;
         $display("FAIL res_timeout: res_valid never rose at %0t", $time);
      end
      if (lit) begin
         chk("lit_result", result, er);
         chk("lit_carry", carry, ec);
         chk("lit_overflow", overflow, eo);
      end
      held = result;
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            start_valid = (i == 0) && (hold >= 2);
         end
         start_valid = 1'b0;
         @(negedge clk);
         chk("hold_result", result, held);
         chk("hold_valid", res_valid, 1);
         @(posedge clk); #1;
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin
      #1;
      chk("init_result", result, 0);
      chk("init_res_valid", res_valid, 0);
      chk("init_busy", busy, 0);
      chk("init_start_ready", start_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      op(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 0);
      op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      op(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0);
      op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
      op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 5);
      op(16'h1357, 16'h0246, 1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 0);

      // Reset in the middle of RUN, between slices 1 and 2.
      a = 16'h1234; b = 16'h1111; sub = 1'b0; start_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_result", result, 0);
      chk("midrun_res_valid", res_valid, 0);
      chk("midrun_busy", busy, 0);
      chk("midrun_carry", carry, 0);
      chk("midrun_overflow", overflow, 0);
      chk("midrun_start_ready", start_ready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      op(16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 0);

      // Randomized traffic, biased toward corner operands some of the time.
      for (int n = 0; n < 60; n++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
         if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
         op(ra, rb, 1'($urandom), 1'b0, '0, 1'b0, 1'b0, $urandom_range(0, 3));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
